// File: rtl/regfile_multiport_if.sv
// regfile_multiport_if -- port bundle for regfile_multiport.
//   RA/RB/RC     : read addresses           BusA/BusB/BusC : read data
//   RW0/RW1      : write addresses          BusW0/BusW1    : write data
//   RegWr0/1     : write enables            ByteEn0/1      : per-byte write masks
//   WrConflict   : sticky same-byte collision flag
//   WrCount      : committed write operations (wraps at 2^16)
// master = datapath driving the file, slave = the register file itself.
interface regfile_multiport_if #(
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 5
);
  localparam int NB = WIDTH / 8;

  logic [ADDR_W-1:0] RA, RB, RC;
  logic [WIDTH-1:0]  BusA, BusB, BusC;
  logic [ADDR_W-1:0] RW0, RW1;
  logic [WIDTH-1:0]  BusW0, BusW1;
  logic              RegWr0, RegWr1;
  logic [NB-1:0]     ByteEn0, ByteEn1;
  logic              WrConflict;
  logic [15:0]       WrCount;

  modport master (
    output RA, RB, RC, RW0, RW1, BusW0, BusW1, RegWr0, RegWr1, ByteEn0, ByteEn1,
    input  BusA, BusB, BusC, WrConflict, WrCount
  );

  modport slave (
    input  RA, RB, RC, RW0, RW1, BusW0, BusW1, RegWr0, RegWr1, ByteEn0, ByteEn1,
    output BusA, BusB, BusC, WrConflict, WrCount
  );
endinterface

// File: rtl/regfile_multiport.sv
// regfile_multiport -- DEPTH x WIDTH register file, three combinational read
// ports, two byte-masked write ports committing on the falling edge of Clk,
// optional hardwired zero register, sticky write-collision flag and a
// committed-write counter.
//   Clk   : clock, writes commit on its falling edge
//   Reset : asynchronous active-high clear of all state
//   bus   : regfile_multiport_if.slave (read/write ports, status outputs)

// One storage row. Byte lanes enabled on port 1 win over port 0, which gives
// the collision priority for free when both ports target this row.
module regfile_multiport_row #(
  parameter int WIDTH = 64
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               we0_i,
  input  logic               we1_i,
  input  logic [WIDTH/8-1:0] be0_i,
  input  logic [WIDTH/8-1:0] be1_i,
  input  logic [WIDTH-1:0]   wd0_i,
  input  logic [WIDTH-1:0]   wd1_i,
  output logic [WIDTH-1:0]   q_o
);
  localparam int NB = WIDTH / 8;

  logic [NB-1:0][7:0] row_q, row_d, wd0_b, wd1_b;

  assign wd0_b = wd0_i;
  assign wd1_b = wd1_i;

  always_comb begin
    row_d = row_q;
    for (int b = 0; b < NB; b++) begin
      if (we1_i && be1_i[b])      row_d[b] = wd1_b[b];
      else if (we0_i && be0_i[b]) row_d[b] = wd0_b[b];
    end
  end

  always_ff @(negedge Clk or posedge Reset) begin
    if (Reset) row_q <= '0;
    else       row_q <= row_d;
  end

  assign q_o = row_q;
endmodule

module regfile_multiport #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_EN  = 1,
  parameter int ZERO_REG = 31
) (
  input  logic                Clk,
  input  logic                Reset,
  regfile_multiport_if.slave  bus
);
  localparam int NB = WIDTH / 8;

  logic [DEPTH-1:0][WIDTH-1:0] rows;
  logic        eff0, eff1;
  logic [15:0] cnt_q, cnt_d;
  logic        conf_q, conf_d;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_EN != 0) && (32'(a) == ZERO_REG);
  endfunction

  // Read mux by explicit compare so out-of-range addresses fall through to 0
  // instead of aliasing onto a real row.
  function automatic logic [WIDTH-1:0] rd(input logic [ADDR_W-1:0] a,
                                          input logic [DEPTH-1:0][WIDTH-1:0] rr);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int r = 0; r < DEPTH; r++)
      if (32'(a) == r) v = rr[r];
    return v;
  endfunction

  // A port is effective when enabled, in range and not aimed at the zero reg.
  assign eff0 = bus.RegWr0 && in_range(bus.RW0) && !is_zero(bus.RW0);
  assign eff1 = bus.RegWr1 && in_range(bus.RW1) && !is_zero(bus.RW1);

  for (genvar r = 0; r < DEPTH; r++) begin : g_row
    if ((ZERO_EN != 0) && (r == ZERO_REG)) begin : g_zero
      // No storage at all for the hardwired zero register.
      assign rows[r] = '0;
    end else begin : g_reg
      logic w0, w1;
      assign w0 = eff0 && (32'(bus.RW0) == r);
      assign w1 = eff1 && (32'(bus.RW1) == r);
      regfile_multiport_row #(.WIDTH(WIDTH)) u_row (
        .Clk   (Clk),
        .Reset (Reset),
        .we0_i (w0),
        .we1_i (w1),
        .be0_i (bus.ByteEn0),
        .be1_i (bus.ByteEn1),
        .wd0_i (bus.BusW0),
        .wd1_i (bus.BusW1),
        .q_o   (rows[r])
      );
    end
  end

  assign bus.BusA = rd(bus.RA, rows);
  assign bus.BusB = rd(bus.RB, rows);
  assign bus.BusC = rd(bus.RC, rows);

  // A write with an all-zero mask changes nothing, so it is not counted.
  always_comb begin
    cnt_d  = cnt_q + 16'(eff0 && (|bus.ByteEn0)) + 16'(eff1 && (|bus.ByteEn1));
    conf_d = conf_q;
    if (eff0 && eff1 && (bus.RW0 == bus.RW1) && (|(bus.ByteEn0 & bus.ByteEn1)))
      conf_d = 1'b1;
  end

  always_ff @(negedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q  <= '0;
      conf_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      conf_q <= conf_d;
    end
  end

  assign bus.WrCount    = cnt_q;
  assign bus.WrConflict = conf_q;
endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport -- directed bench: a main 64x32 instance driven from a
// vector table plus hand-written sequences, a ZERO_EN=0 instance and a
// 32-bit/16-deep instance for out-of-range and mid-cycle reset behaviour.
module tb_regfile_multiport;
  logic Clk, rst_m, rst_z, rst_s;
  int n_cmp = 0;
  int n_err = 0;

  regfile_multiport_if #(.WIDTH(64), .ADDR_W(5)) if_m ();
  regfile_multiport_if #(.WIDTH(64), .ADDR_W(5)) if_z ();
  regfile_multiport_if #(.WIDTH(32), .ADDR_W(5)) if_s ();

  regfile_multiport #(.WIDTH(64), .DEPTH(32), .ADDR_W(5), .ZERO_EN(1), .ZERO_REG(31))
    u_m (.Clk(Clk), .Reset(rst_m), .bus(if_m));
  regfile_multiport #(.WIDTH(64), .DEPTH(32), .ADDR_W(5), .ZERO_EN(0), .ZERO_REG(31))
    u_z (.Clk(Clk), .Reset(rst_z), .bus(if_z));
  regfile_multiport #(.WIDTH(32), .DEPTH(16), .ADDR_W(5), .ZERO_EN(1), .ZERO_REG(31))
    u_s (.Clk(Clk), .Reset(rst_s), .bus(if_s));

  // Falling edges at 5, 15, 25 ...; rising edges at 10, 20 ...
  initial begin
    Clk = 1'b1;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    logic [4:0]  ra, rb, rc;
    logic [4:0]  rw0; logic we0; logic [7:0] be0; logic [63:0] wd0;
    logic [4:0]  rw1; logic we1; logic [7:0] be1; logic [63:0] wd1;
    logic [63:0] b_pre, a_exp, b_exp, c_exp;
    logic [15:0] cnt_exp;
    logic        conf_exp;
  } vec_t;

  vec_t tv[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_m();
    if_m.RA = 0; if_m.RB = 0; if_m.RC = 0; if_m.RW0 = 0; if_m.RW1 = 0;
    if_m.BusW0 = 0; if_m.BusW1 = 0; if_m.RegWr0 = 0; if_m.RegWr1 = 0;
    if_m.ByteEn0 = 0; if_m.ByteEn1 = 0;
  endtask

  task automatic idle_z();
    if_z.RA = 0; if_z.RB = 0; if_z.RC = 0; if_z.RW0 = 0; if_z.RW1 = 0;
    if_z.BusW0 = 0; if_z.BusW1 = 0; if_z.RegWr0 = 0; if_z.RegWr1 = 0;
    if_z.ByteEn0 = 0; if_z.ByteEn1 = 0;
  endtask

  task automatic idle_s();
    if_s.RA = 0; if_s.RB = 0; if_s.RC = 0; if_s.RW0 = 0; if_s.RW1 = 0;
    if_s.BusW0 = 0; if_s.BusW1 = 0; if_s.RegWr0 = 0; if_s.RegWr1 = 0;
    if_s.ByteEn0 = 0; if_s.ByteEn1 = 0;
  endtask

  initial begin
    //           ra  rb  rc   rw0 we0 be0    wd0                      rw1 we1 be1    wd1                      b_pre                    a_exp                    b_exp                    c_exp                    cnt conf
    tv[0] = '{5'd31,5'd31,5'd0, 5'd31,1'b1,8'hFF,64'hDEADBEEF,          5'd0,1'b0,8'h00,64'h0,                 64'h0,                   64'h0,                   64'h0,                   64'h0,                   16'd0,1'b0};
    tv[1] = '{5'd0, 5'd5, 5'd5, 5'd5, 1'b1,8'hFF,64'h1111_1111_1111_1111,5'd0,1'b0,8'h00,64'h0,                 64'h0,                   64'h0,                   64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111, 16'd1,1'b0};
    tv[2] = '{5'd5, 5'd5, 5'd5, 5'd5, 1'b1,8'h0F,64'hFFFF_FFFF_FFFF_FFFF,5'd0,1'b0,8'h00,64'h0,                 64'h1111_1111_1111_1111, 64'h1111_1111_FFFF_FFFF, 64'h1111_1111_FFFF_FFFF, 64'h1111_1111_FFFF_FFFF, 16'd2,1'b0};
    tv[3] = '{5'd10,5'd11,5'd5, 5'd10,1'b1,8'hFF,64'h1010,              5'd11,1'b1,8'hFF,64'h103000,           64'h0,                   64'h1010,                64'h103000,              64'h1111_1111_FFFF_FFFF, 16'd4,1'b0};
    tv[4] = '{5'd13,5'd13,5'd13,5'd13,1'b1,8'hF0,64'hAAAA_AAAA_AAAA_AAAA,5'd13,1'b1,8'h0F,64'hBBBB_BBBB_BBBB_BBBB,64'h0,                   64'hAAAA_AAAA_BBBB_BBBB, 64'hAAAA_AAAA_BBBB_BBBB, 64'hAAAA_AAAA_BBBB_BBBB, 16'd6,1'b0};
    tv[5] = '{5'd11,5'd13,5'd10,5'd13,1'b1,8'hF0,64'hAAAA_AAAA_AAAA_AAAA,5'd13,1'b1,8'h3C,64'hBBBB_BBBB_BBBB_BBBB,64'hAAAA_AAAA_BBBB_BBBB, 64'h103000,              64'hAAAA_BBBB_BBBB_BBBB, 64'h1010,                16'd8,1'b1};
    tv[6] = '{5'd10,5'd10,5'd13,5'd10,1'b1,8'h00,64'h0,                 5'd0,1'b0,8'h00,64'h0,                 64'h1010,                64'h1010,                64'h1010,                64'hAAAA_BBBB_BBBB_BBBB, 16'd8,1'b1};
    tv[7] = '{5'd31,5'd11,5'd13,5'd0, 1'b0,8'h00,64'h0,                 5'd11,1'b0,8'hFF,64'h0,                 64'h103000,              64'h0,                   64'h103000,              64'hAAAA_BBBB_BBBB_BBBB, 16'd8,1'b1};

    rst_m = 1'b1; rst_z = 1'b1; rst_s = 1'b1;
    idle_m(); idle_z(); idle_s();
    @(posedge Clk); #2;
    rst_m = 1'b0; rst_z = 1'b0; rst_s = 1'b0;
    chk("reset_cnt", 64'(if_m.WrCount), 64'd0);
    chk("reset_conf", 64'(if_m.WrConflict), 64'd0);

    // Preload regs 0..30 with their own index, two per edge.
    for (int i = 0; i < 31; i += 2) begin
      @(posedge Clk); #1;
      if_m.RW0 = 5'(i); if_m.BusW0 = 64'(i); if_m.RegWr0 = 1'b1; if_m.ByteEn0 = 8'hFF;
      if_m.RW1 = 5'(i + 1); if_m.BusW1 = 64'(i + 1); if_m.ByteEn1 = 8'hFF;
      if_m.RegWr1 = (i + 1 < 31);
      @(negedge Clk);
    end
    @(posedge Clk); #1;
    idle_m();
    if_m.RA = 5'd5; if_m.RB = 5'd30; if_m.RC = 5'd7;
    #1;
    chk("preload_a5", if_m.BusA, 64'd5);
    chk("preload_b30", if_m.BusB, 64'd30);
    chk("preload_c7", if_m.BusC, 64'd7);
    chk("preload_cnt", 64'(if_m.WrCount), 64'd31);

    // 3 ns reset pulse between edges.
    @(posedge Clk); #1;
    if_m.RA = 5'd0; if_m.RB = 5'd5; if_m.RC = 5'd30;
    rst_m = 1'b1;
    #1;
    chk("rst_a0", if_m.BusA, 64'd0);
    chk("rst_b5", if_m.BusB, 64'd0);
    chk("rst_c30", if_m.BusC, 64'd0);
    chk("rst_cnt", 64'(if_m.WrCount), 64'd0);
    chk("rst_conf", 64'(if_m.WrConflict), 64'd0);
    #2;
    rst_m = 1'b0;

    for (int k = 0; k < 8; k++) begin
      @(posedge Clk); #1;
      if_m.RA = tv[k].ra; if_m.RB = tv[k].rb; if_m.RC = tv[k].rc;
      if_m.RW0 = tv[k].rw0; if_m.RegWr0 = tv[k].we0; if_m.ByteEn0 = tv[k].be0; if_m.BusW0 = tv[k].wd0;
      if_m.RW1 = tv[k].rw1; if_m.RegWr1 = tv[k].we1; if_m.ByteEn1 = tv[k].be1; if_m.BusW1 = tv[k].wd1;
      #1;
      chk($sformatf("v%0d_b_pre", k), if_m.BusB, tv[k].b_pre);
      @(negedge Clk); #1;
      chk($sformatf("v%0d_a", k), if_m.BusA, tv[k].a_exp);
      chk($sformatf("v%0d_b", k), if_m.BusB, tv[k].b_exp);
      chk($sformatf("v%0d_c", k), if_m.BusC, tv[k].c_exp);
      chk($sformatf("v%0d_cnt", k), 64'(if_m.WrCount), 64'(tv[k].cnt_exp));
      chk($sformatf("v%0d_conf", k), 64'(if_m.WrConflict), 64'(tv[k].conf_exp));
    end
    @(posedge Clk); #1;
    idle_m();
    repeat (5) @(negedge Clk);
    #1;
    chk("conf_sticky", 64'(if_m.WrConflict), 64'd1);
    chk("cnt_idle", 64'(if_m.WrCount), 64'd8);

    // Instance without a zero register: reg 31 is ordinary storage.
    @(posedge Clk); #1;
    if_z.RW0 = 5'd31; if_z.BusW0 = 64'hDEADBEEF; if_z.RegWr0 = 1'b1; if_z.ByteEn0 = 8'hFF;
    if_z.RA = 5'd31;
    @(negedge Clk); #1;
    chk("z_a31", if_z.BusA, 64'hDEADBEEF);
    chk("z_cnt", 64'(if_z.WrCount), 64'd1);
    @(posedge Clk); #1;
    idle_z();

    // 32-bit, 16-deep: address 20 is out of range and must not alias reg 4.
    @(posedge Clk); #1;
    if_s.RW0 = 5'd20; if_s.BusW0 = 32'h12345678; if_s.RegWr0 = 1'b1; if_s.ByteEn0 = 4'hF;
    if_s.RW1 = 5'd4;  if_s.BusW1 = 32'hCAFEF00D; if_s.RegWr1 = 1'b1; if_s.ByteEn1 = 4'hF;
    if_s.RA = 5'd20; if_s.RB = 5'd4; if_s.RC = 5'd20;
    @(negedge Clk); #1;
    chk("s_a20", 64'(if_s.BusA), 64'd0);
    chk("s_b4", 64'(if_s.BusB), 64'hCAFEF00D);
    chk("s_c20", 64'(if_s.BusC), 64'd0);
    chk("s_cnt1", 64'(if_s.WrCount), 64'd1);

    @(posedge Clk); #1;
    if_s.RW0 = 5'd3; if_s.BusW0 = 32'h12345678; if_s.RegWr0 = 1'b1; if_s.ByteEn0 = 4'hF;
    if_s.RegWr1 = 1'b0;
    if_s.RA = 5'd3;
    @(negedge Clk); #1;
    chk("s_a3_written", 64'(if_s.BusA), 64'h12345678);
    chk("s_cnt2", 64'(if_s.WrCount), 64'd2);

    // Port 1 keeps writing reg 3 while reset is asserted mid-cycle.
    @(posedge Clk); #1;
    if_s.RegWr0 = 1'b0;
    if_s.RW1 = 5'd3; if_s.BusW1 = 32'h87654321; if_s.RegWr1 = 1'b1; if_s.ByteEn1 = 4'hF;
    #1;
    rst_s = 1'b1;
    #1;
    chk("s_rst_a3", 64'(if_s.BusA), 64'd0);
    chk("s_rst_cnt", 64'(if_s.WrCount), 64'd0);
    @(negedge Clk); #1;
    chk("s_rst_hold_a3", 64'(if_s.BusA), 64'd0);
    chk("s_rst_hold_cnt", 64'(if_s.WrCount), 64'd0);
    @(posedge Clk); #1;
    idle_s();
    #1;
    rst_s = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
